// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared definitions for the serial-pattern detector family.
//               It holds the pattern-length width function, the reset
//               configuration defaults and the match-mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Match-mode encoding for the overlap flag
    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    // Reset configuration: detect "101" with non-overlapping matches
    localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_0101;
    localparam int         DEFAULT_LEN     = 3;
    localparam logic       DEFAULT_OVERLAP = MODE_NONOVL;

    // The width needed to hold a length value in the range 0..max_len
    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
//               Priority: clr, then inc, then hold. Holds at all-ones.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset (q -> 0)
//               clr  - synchronous clear (q -> 0)
//               inc  - count enable
//               q    - counter value [W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param
// Description : Runtime-programmable Mealy serial-pattern detector. It detects
//               a right-aligned pattern of 2..MAX_LEN bits on a 1-bit stream.
//               Matches may overlap or not, and they are counted in a
//               saturating counter.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               in_valid, data_in  - serial input bit and its qualifier
//               cfg_load           - load cfg_pattern / cfg_len / cfg_overlap
//               cnt_clr            - synchronous clear of match_cnt
//               match              - combinational match for the current bit
//               match_cnt          - saturating match count
//               cfg_err            - one-cycle pulse after an illegal cfg_load
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEFAULT_PATTERN),
    parameter int                 DEF_LEN     = DEFAULT_LEN,
    parameter logic               DEF_OVERLAP = DEFAULT_OVERLAP,
    localparam int                LEN_W       = calc_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               data_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] C_MIN_LEN  = LEN_W'(2);
    localparam logic [LEN_W-1:0] C_MAX_LEN  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] C_FILL_MAX = LEN_W'(MAX_LEN - 1);

    // State
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;
    logic               r_cfg_err;

    // Next-state and combinational results
    logic [MAX_LEN-2:0] w_hist_nxt;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [MAX_LEN-1:0] w_pat_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic               w_ovl_nxt;
    logic               w_cfg_err_nxt;
    logic               w_match;
    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_cfg_legal;

    always_comb begin
        w_hist_nxt    = r_hist;
        w_fill_nxt    = r_fill;
        w_pat_nxt     = r_pat;
        w_len_nxt     = r_len;
        w_ovl_nxt     = r_ovl;
        w_cfg_err_nxt = 1'b0;
        w_match       = 1'b0;
        w_mask        = '0;

        // The newest MAX_LEN bits including the one arriving now. Its low
        // MAX_LEN-1 bits are also exactly the shifted-in history.
        w_window = {r_hist, data_in};

        // Only the low r_len bits of the window and pattern take part
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end

        w_cfg_legal = (cfg_len >= C_MIN_LEN) && (cfg_len <= C_MAX_LEN);

        if (rst) begin
            w_match = 1'b0;
        end else if (cfg_load) begin
            // The bit presented alongside a load is always discarded
            if (w_cfg_legal) begin
                w_pat_nxt  = cfg_pattern;
                w_len_nxt  = cfg_len;
                w_ovl_nxt  = cfg_overlap;
                // Bits older than the reconfiguration must never match
                w_fill_nxt = '0;
            end else begin
                w_cfg_err_nxt = 1'b1;
            end
        end else if (in_valid) begin
            // r_fill gates out history bits that predate reset, a reload or
            // the previous non-overlapping match.
            w_match = (r_fill >= (r_len - LEN_W'(1))) &&
                      ((w_window & w_mask) == (r_pat & w_mask));
            w_hist_nxt = w_window[MAX_LEN-2:0];
            if (w_match && (r_ovl == MODE_NONOVL)) begin
                w_fill_nxt = '0;
            end else if (r_fill != C_FILL_MAX) begin
                w_fill_nxt = r_fill + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist    <= '0;
            r_fill    <= '0;
            r_pat     <= DEF_PATTERN;
            r_len     <= LEN_W'(DEF_LEN);
            r_ovl     <= DEF_OVERLAP;
            r_cfg_err <= 1'b0;
        end else begin
            r_hist    <= w_hist_nxt;
            r_fill    <= w_fill_nxt;
            r_pat     <= w_pat_nxt;
            r_len     <= w_len_nxt;
            r_ovl     <= w_ovl_nxt;
            r_cfg_err <= w_cfg_err_nxt;
        end
    end

    sat_counter #(
        .W   (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_match),
        .q   (match_cnt)
    );

    assign match   = w_match;
    assign cfg_err = r_cfg_err;

endmodule : seq_detect_param
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_param
// Description : Self-checking bench for seq_detect_param (MAX_LEN=8, CNT_W=2).
//               Expected match bits are queued as each bit is driven and
//               popped when the DUT's Mealy output is sampled. The counter and
//               cfg_err expectations come from a small bench-side model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               data_in;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];
    int exp_cnt  = 0;
    bit exp_err  = 1'b0;

    seq_detect_param #(
        .MAX_LEN     (MAX_LEN),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .data_in     (data_in),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .match       (match),
        .match_cnt   (match_cnt),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive at posedge+1, check match mid-cycle, then check
    // the registered outputs 1 time unit after the next posedge.
    task automatic cycle(input string tag, input bit v, input bit d,
                         input bit load, input bit clr, input bit exp_m);
        bit e;
        bit ill;
        in_valid = v;
        data_in  = d;
        cfg_load = load;
        cnt_clr  = clr;
        exp_q.push_back(exp_m);
        #3;
        e = exp_q.pop_front();
        n_checks++;
        if (match !== e)
            $display("FAIL %s match: actual=%b required=%b", tag, match, e);
        else
            n_pass++;
        ill = load && ((int'(cfg_len) < 2) || (int'(cfg_len) > MAX_LEN));
        if (rst || clr)
            exp_cnt = 0;
        else if (exp_m && (exp_cnt < CNT_MAX))
            exp_cnt++;
        exp_err = !rst && ill;
        @(posedge clk);
        #1;
        n_checks++;
        if (match_cnt !== CNT_W'(exp_cnt))
            $display("FAIL %s match_cnt: actual=%0d required=%0d", tag, match_cnt, exp_cnt);
        else
            n_pass++;
        n_checks++;
        if (cfg_err !== exp_err)
            $display("FAIL %s cfg_err: actual=%b required=%b", tag, cfg_err, exp_err);
        else
            n_pass++;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    // Sends n bits, bits[n-1] first; exp holds the expected match per bit
    task automatic send(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(tag, 1'b1, bits[i], 1'b0, 1'b0, exp[i]);
        end
    endtask

    task automatic load_cfg(input string tag, input logic [MAX_LEN-1:0] p,
                            input int l, input bit o, input bit d);
        cfg_pattern = p;
        cfg_len     = LEN_W'(l);
        cfg_overlap = o;
        cycle(tag, 1'b1, d, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_cnt();
        cycle("clr", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_default_nonovl();
        send("dflt_101", 5, 16'b10101, 16'b00100);
    endtask

    task automatic test_overlap_101();
        clear_cnt();
        load_cfg("ld_101_ovl", 8'b101, 3, 1'b1, 1'b1);
        send("ovl_101", 5, 16'b10101, 16'b00101);
    endtask

    task automatic test_len4();
        clear_cnt();
        load_cfg("ld_1101", 8'b1101, 4, 1'b0, 1'b0);
        send("nonovl_1101", 7, 16'b1101101, 16'b0001000);
        load_cfg("ld_1101_ovl", 8'b1101, 4, 1'b1, 1'b1);
        send("ovl_1101", 7, 16'b1101101, 16'b0001001);
    endtask

    task automatic test_max_len();
        clear_cnt();
        load_cfg("ld_len8", 8'b1011_0011, 8, 1'b0, 1'b1);
        send("len8", 8, 16'b1011_0011, 16'b0000_0001);
    endtask

    task automatic test_gaps();
        clear_cnt();
        load_cfg("ld_101", 8'b101, 3, 1'b0, 1'b1);
        cycle("gap_b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("gap_1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("gap_b2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("gap_2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("gap_b3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_cfg_load();
        clear_cnt();
        load_cfg("ill_len1", 8'b11, 1, 1'b1, 1'b1);
        send("after_len1", 3, 16'b101, 16'b001);
        send("pre_len9", 2, 16'b10, 16'b00);
        load_cfg("ill_len9", 8'b11, MAX_LEN + 1, 1'b1, 1'b0);
        send("after_len9", 1, 16'b1, 16'b1);
        send("pre_reload", 2, 16'b10, 16'b00);
        load_cfg("mid_reload", 8'b101, 3, 1'b0, 1'b1);
        send("after_reload", 1, 16'b1, 16'b0);
        send("fresh_101", 2, 16'b01, 16'b01);
    endtask

    task automatic test_saturation();
        clear_cnt();
        send("sat", 15, 16'b101101101101101, 16'b001001001001001);
        send("pre_clr", 2, 16'b10, 16'b00);
        cycle("clr_vs_match", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_mid_reset();
        load_cfg("ld_11", 8'b11, 2, 1'b1, 1'b0);
        send("pre_rst", 2, 16'b10, 16'b00);
        rst = 1'b1;
        cycle("mid_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        send("post_rst", 3, 16'b101, 16'b001);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        data_in     = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_default_nonovl();
        test_overlap_101();
        test_len4();
        test_max_len();
        test_gaps();
        test_cfg_load();
        test_saturation();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seq_detect_param
`default_nettype wire

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-programmable Mealy serial-pattern detector. It generalises the fixed 101 detector to any pattern of 2..MAX_LEN bits, with overlapping or non-overlapping match mode and a saturating match counter. It sits on a 1-bit serial stream alongside the other sequence-detection FSM blocks. The match pulse is combinational in the cycle the final pattern bit arrives.

## Interface
Parameters:
- MAX_LEN, 8: maximum pattern length in bits; legal range is 2 or more.
- CNT_W, 16: width of the match counter.
- DEF_PATTERN, 8'b0000_0101: reset pattern, right-aligned; bit 0 is the last bit received.
- DEF_LEN, 3: reset pattern length.
- DEF_OVERLAP, 1'b0: reset match mode.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: data_in is sampled this cycle.
- data_in, in, 1: serial data bit.
- cfg_load, in, 1: load a new configuration this cycle.
- cfg_pattern, in, MAX_LEN: new pattern, right-aligned.
- cfg_len, in, LEN_W = $clog2(MAX_LEN+1): new pattern length.
- cfg_overlap, in, 1: 1 selects overlapping mode, 0 selects non-overlapping mode.
- cnt_clr, in, 1: synchronous clear of the match counter.
- match, out, 1: Mealy output; high when the current valid bit completes the pattern.
- match_cnt, out, CNT_W: saturating count of matches.
- cfg_err, out, 1: registered one-cycle pulse after an illegal cfg_load.

## Operation
State registers:
- hist[MAX_LEN-2:0]: most recent valid bits, newest in bit 0.
- fill: number of valid history bits, saturating at MAX_LEN-1.
- pat, len, ovl: active configuration.

Per cycle with in_valid=1 and cfg_load=0:
- match = (fill ≥ len-1) && ({hist, data_in} masked to len bits == pat masked to len bits).
- hist shifts left and takes data_in.
- On match in overlap mode (ovl=1): fill increments (saturating); history is retained.
- On match in non-overlap mode (ovl=0): fill is set to 0, so the next match needs len fresh bits.
- With no match: fill increments (saturating).

Other cases:
- in_valid=0: state is held and match=0.
- cfg_load with 2 ≤ cfg_len ≤ MAX_LEN: pat, len and ovl are loaded and fill is set to 0. The bit presented in the same cycle is discarded, match=0, and the new configuration applies from the next cycle.
- cfg_load with an illegal cfg_len: the configuration is unchanged, fill is unchanged, the bit is discarded, and cfg_err pulses on the next cycle.
- Counter: increments on match and holds at 2^CNT_W-1. cnt_clr takes priority over an increment in the same cycle, so the result is 0.

Reset values:
- pat=DEF_PATTERN, len=DEF_LEN, ovl=DEF_OVERLAP.
- hist=0, fill=0, match_cnt=0, cfg_err=0.
- match is forced to 0 while rst=1.

## Timing
- match is combinational from data_in, in_valid and state, with zero-cycle latency. Downstream logic registers it if needed.
- match_cnt updates on the clock edge after a match, giving 1-cycle latency.
- cfg_err is registered and appears 1 cycle after the illegal load.
- rst mid-pattern discards all partial history. The first possible match is len valid bits after rst deasserts.
- Bits in history that predate a reconfiguration never contribute to a match.

## Structure
- Shared package seq_det_pkg holds:
  - the LEN_W computation function;
  - default pattern, length and overlap constants;
  - the mode encoding localparams MODE_NONOVL=0 and MODE_OVL=1.
- One sub-module, sat_counter (parameter W; ports clk, rst, clr, inc, q), implements the match counter. Priority is clr, then inc, then hold.
- The remainder is a single always_ff for state and a single always_comb for match and next-state. There are no latches, and every branch assigns a default.

## Test plan
- Reset defaults (101, non-overlap), stream 1,0,1,0,1 with in_valid=1: match high on bit 3 only; match_cnt=1.
- Load cfg_pattern=101, cfg_len=3, cfg_overlap=1, then the same stream: match on bits 3 and 5; match_cnt=2.
- Load pattern 1101, length 4, non-overlap, stream 1,1,0,1,1,0,1: match on bit 4 only. Reload with overlap and repeat the stream: match on bits 4 and 7.
- in_valid gaps: stream 1,(gap),0,(gap),1 under the 101 default: match on the third valid bit, and match stays low during gaps.
- Illegal load cfg_len=1 or cfg_len=MAX_LEN+1: cfg_err pulses once and the previous pattern still detects. cfg_load mid-pattern (after 1,0 of 101), followed by 1: no match.
- CNT_W=2, five matches: match_cnt saturates at 3. cnt_clr coincident with a match gives 0. rst asserted after 1,0 then released, followed by 1: no match.
